// File: rtl/keypad_bcd_entry.sv
// Scans a 4x4 active-low keypad and debounces whole scan frames. Collects up to
// three packed-BCD digits and converts them on '#' to a saturated 8-bit value.

module keypad_bcd_entry #(
   parameter logic [19:0] CNT_SCAN_MAX = 20'd49_999,
   parameter logic [3:0]  DEB_FRAMES   = 4'd5
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  key_col,
   output logic [3:0]  key_row,
   output logic [11:0] bcd_disp,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        overflow
);

   localparam logic [3:0] IDX_STAR  = 4'd12;
   localparam logic [3:0] IDX_ENTER = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [19:0] cnt_scan;
   logic [1:0]  row;
   logic [3:0]  col_meta;
   logic [3:0]  col_sync;
   logic [11:0] raw;
   logic        slot_end;
   logic        frame_end;
   logic [15:0] frame;
   logic [15:0] prev_frame;
   logic [4:0]  ones;
   logic [3:0]  key_idx;
   logic        single;
   logic        none;
   logic [3:0]  deb_cnt;
   logic [3:0]  deb_cnt_nxt;
   logic        pressed;
   logic        key_evt;
   logic        release_ok;
   logic        dig_valid;
   logic [3:0]  dig_val;
   state_t      state;
   state_t      state_nxt;
   logic [1:0]  step;
   logic [1:0]  step_nxt;
   logic [9:0]  acc;
   logic [9:0]  acc_nxt;
   logic [3:0]  conv_dig;
   logic        load;
   logic [1:0]  ndig;

   assign slot_end  = (cnt_scan == CNT_SCAN_MAX);
   assign frame_end = slot_end && (row == 2'd3);
   assign key_row   = ~(4'b0001 << row);
   // Row 3 is never stored: at the frame end its columns are read straight from the synchroniser.
   assign frame     = {~col_sync, raw};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_scan <= '0;
         row      <= '0;
         col_meta <= 4'hF;
         col_sync <= 4'hF;
         // NOTE: the per-row sample store is a handful of flops, so it is reset like any other register.
         raw      <= '0;
      end else begin
         col_meta <= key_col;
         col_sync <= col_meta;
         if (slot_end) begin
            cnt_scan <= '0;
            row      <= row + 2'd1;
            case (row)
               2'd0:    raw[3:0]  <= ~col_sync;
               2'd1:    raw[7:4]  <= ~col_sync;
               2'd2:    raw[11:8] <= ~col_sync;
               default: ;
            endcase
         end else begin
            cnt_scan <= cnt_scan + 20'd1;
         end
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      ones    = '0;
      key_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            ones    = ones + 5'd1;
            key_idx = 4'(i);
         end
      end
   end

   assign single = (ones == 5'd1);
   assign none   = (ones == 5'd0);

   always_comb begin
      if (!single && !none) begin
         deb_cnt_nxt = '0;
      end else if (frame != prev_frame) begin
         deb_cnt_nxt = 4'd1;
      end else if (deb_cnt < DEB_FRAMES) begin
         deb_cnt_nxt = deb_cnt + 4'd1;
      end else begin
         deb_cnt_nxt = deb_cnt;
      end
   end

   assign key_evt    = frame_end && single && !pressed && (deb_cnt_nxt == DEB_FRAMES);
   assign release_ok = frame_end && none && (deb_cnt_nxt == DEB_FRAMES);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_frame <= '0;
         deb_cnt    <= '0;
         pressed    <= 1'b0;
      end else if (frame_end) begin
         prev_frame <= frame;
         deb_cnt    <= deb_cnt_nxt;
         if (key_evt) begin
            pressed <= 1'b1;
         end else if (release_ok) begin
            pressed <= 1'b0;
         end
      end
   end

   // Legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
   always_comb begin
      dig_valid = 1'b1;
      dig_val   = '0;
      case (key_idx)
         4'd0:    dig_val = 4'd1;
         4'd1:    dig_val = 4'd2;
         4'd2:    dig_val = 4'd3;
         4'd4:    dig_val = 4'd4;
         4'd5:    dig_val = 4'd5;
         4'd6:    dig_val = 4'd6;
         4'd8:    dig_val = 4'd7;
         4'd9:    dig_val = 4'd8;
         4'd10:   dig_val = 4'd9;
         4'd13:   dig_val = 4'd0;
         default: dig_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      acc_nxt   = acc;
      load      = 1'b0;
      case (step)
         2'd0:    conv_dig = bcd_disp[11:8];
         2'd1:    conv_dig = bcd_disp[7:4];
         default: conv_dig = bcd_disp[3:0];
      endcase
      case (state)
         IDLE: begin
            if (key_evt && (key_idx == IDX_ENTER)) begin
               state_nxt = CONV;
               step_nxt  = '0;
               acc_nxt   = '0;
            end
         end
         CONV: begin
            acc_nxt  = acc * 10'd10 + {6'd0, conv_dig};
            step_nxt = step + 2'd1;
            // The final digit's result is registered into the outputs on the way into DONE.
            if (step == 2'd2) begin
               state_nxt = DONE;
               load      = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         step  <= '0;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         acc   <= acc_nxt;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bcd_disp   <= '0;
         ndig       <= '0;
         data_out   <= '0;
         overflow   <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= load;
         if (load) begin
            bcd_disp <= '0;
            ndig     <= '0;
            data_out <= (acc_nxt > 10'd255) ? 8'd255 : acc_nxt[7:0];
            overflow <= (acc_nxt > 10'd255);
         end else if (key_evt && (state == IDLE)) begin
            if (dig_valid) begin
               if (ndig != 2'd3) begin
                  bcd_disp <= {bcd_disp[7:0], dig_val};
                  ndig     <= ndig + 2'd1;
               end
            end else if (key_idx == IDX_STAR) begin
               bcd_disp <= '0;
               ndig     <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Self-checking bench for keypad_bcd_entry: a matrix keypad model driven with
// scripted and random key sequences, checked against a digit-list entry model.

module tb_keypad_bcd_entry;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [3:0]  key_col;
   logic [3:0]  key_row;
   logic [11:0] bcd_disp;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        overflow;

   logic [15:0] keys_down;

   int checks = 0;
   int errors = 0;

   int          digits[$];
   string       legend = "123A456B789C*0#D";
   int          dv_cnt;
   int          dv_first;
   logic [11:0] bcd_at31;
   logic [11:0] bcd_at32;

   keypad_bcd_entry #(
      .CNT_SCAN_MAX (20'd3),
      .DEB_FRAMES   (4'd2)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_col    (key_col),
      .key_row    (key_row),
      .bcd_disp   (bcd_disp),
      .data_out   (data_out),
      .data_valid (data_valid),
      .overflow   (overflow)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // A closed key pulls its column low only while its row is driven low.
   always_comb begin
      key_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys_down[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] model_bcd();
      logic [11:0] v;
      v = '0;
      foreach (digits[i]) v = {v[7:0], 4'(digits[i])};
      return v;
   endfunction

   // Waits for the row-3 -> row-0 wrap; returns at cycle 0 of a new frame.
   task automatic align_frame();
      logic [3:0] prev;
      bit         found;
      found = 1'b0;
      prev  = key_row;
      for (int k = 0; k < 64 && !found; k++) begin
         @(negedge sys_clk);
         if (key_row == 4'b1110 && prev == 4'b0111) found = 1'b1;
         prev = key_row;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL align: key_row never wrapped 0111->1110 (last %b)", key_row);
      end
   endtask

   task automatic press_hold(input logic [15:0] mask, input int hold);
      align_frame();
      keys_down = mask;
      dv_cnt    = 0;
      dv_first  = -1;
      bcd_at31  = '0;
      bcd_at32  = '0;
      for (int k = 0; k < hold; k++) begin
         if (data_valid) begin
            dv_cnt++;
            if (dv_first < 0) dv_first = k;
         end
         if (k == 31) bcd_at31 = bcd_disp;
         if (k == 32) bcd_at32 = bcd_disp;
         @(negedge sys_clk);
      end
      keys_down = '0;
      repeat (48) begin
         if (data_valid) dv_cnt++;
         @(negedge sys_clk);
      end
   endtask

   task automatic do_key(input int idx);
      logic [11:0] old_bcd;
      logic [11:0] new_bcd;
      logic [15:0] mask;
      logic [7:0]  exp_do;
      logic        exp_ov;
      byte         ch;
      bit          is_enter;
      int          v;
      old_bcd  = model_bcd();
      ch       = legend[idx];
      is_enter = (ch == "#");
      exp_do   = '0;
      exp_ov   = 1'b0;
      mask     = '0;
      mask[idx] = 1'b1;
      press_hold(mask, 48);
      if (ch >= "0" && ch <= "9") begin
         if (digits.size() < 3) digits.push_back(int'(ch) - int'("0"));
      end else if (ch == "*") begin
         digits.delete();
      end else if (is_enter) begin
         v = 0;
         foreach (digits[i]) v = v * 10 + digits[i];
         exp_do = (v > 255) ? 8'd255 : 8'(v);
         exp_ov = (v > 255);
         digits.delete();
      end
      new_bcd = model_bcd();
      checks++;
      if (bcd_at31 !== old_bcd) begin
         errors++;
         $display("FAIL key %s early: bcd_disp=%h expected %h", string'(ch), bcd_at31, old_bcd);
      end
      if (is_enter) begin
         checks++;
         if (bcd_at32 !== old_bcd) begin
            errors++;
            $display("FAIL enter hold: bcd_disp=%h expected %h", bcd_at32, old_bcd);
         end
         checks++;
         if (dv_cnt !== 1) begin
            errors++;
            $display("FAIL enter pulses: data_valid cycles=%0d expected 1", dv_cnt);
         end
         checks++;
         if (dv_first !== 35) begin
            errors++;
            $display("FAIL enter latency: pulse at offset %0d expected 35", dv_first);
         end
         checks++;
         if (data_out !== exp_do) begin
            errors++;
            $display("FAIL enter data_out: got %0d expected %0d", data_out, exp_do);
         end
         checks++;
         if (overflow !== exp_ov) begin
            errors++;
            $display("FAIL enter overflow: got %b expected %b", overflow, exp_ov);
         end
         checks++;
         if (bcd_disp !== 12'h000) begin
            errors++;
            $display("FAIL enter clear: bcd_disp=%h expected 000", bcd_disp);
         end
      end else begin
         checks++;
         if (bcd_at32 !== new_bcd) begin
            errors++;
            $display("FAIL key %s entry: bcd_disp=%h expected %h", string'(ch), bcd_at32, new_bcd);
         end
         checks++;
         if (dv_cnt !== 0) begin
            errors++;
            $display("FAIL key %s valid: data_valid cycles=%0d expected 0", string'(ch), dv_cnt);
         end
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      keys_down = '0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      checks++;
      if ({bcd_disp, data_out, data_valid, overflow} !== 22'd0) begin
         errors++;
         $display("FAIL reset outputs: bcd=%h dout=%0d dv=%b ovf=%b expected all 0",
                  bcd_disp, data_out, data_valid, overflow);
      end
      for (int k = 0; k <= 16; k++) begin
         logic [3:0] exp_row;
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         checks++;
         if (key_row !== exp_row) begin
            errors++;
            $display("FAIL row walk k=%0d: key_row=%b expected %b", k, key_row, exp_row);
         end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_basic_entry();
      do_key(0);
      do_key(1);
      do_key(9);
      checks++;
      if (bcd_disp !== 12'h128) begin
         errors++;
         $display("FAIL basic bcd: bcd_disp=%h expected 128", bcd_disp);
      end
      do_key(14);
      checks++;
      if (data_out !== 8'd128 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic convert: data_out=%0d ovf=%b expected 128/0", data_out, overflow);
      end
   endtask

   task automatic test_overflow();
      do_key(10);
      do_key(10);
      do_key(10);
      do_key(8);
      checks++;
      if (bcd_disp !== 12'h999) begin
         errors++;
         $display("FAIL fourth digit: bcd_disp=%h expected 999", bcd_disp);
      end
      do_key(14);
      checks++;
      if (data_out !== 8'd255 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL saturate: data_out=%0d ovf=%b expected 255/1", data_out, overflow);
      end
      do_key(4);
      do_key(1);
      do_key(14);
      checks++;
      if (data_out !== 8'd42 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL after overflow: data_out=%0d ovf=%b expected 42/0", data_out, overflow);
      end
   endtask

   task automatic test_debounce();
      press_hold(16'h0020, 16);
      checks++;
      if (bcd_disp !== 12'h000 || dv_cnt !== 0) begin
         errors++;
         $display("FAIL bounce: bcd_disp=%h dv=%0d expected 000/0", bcd_disp, dv_cnt);
      end
      press_hold(16'h0060, 160);
      checks++;
      if (bcd_disp !== 12'h000 || dv_cnt !== 0) begin
         errors++;
         $display("FAIL two keys: bcd_disp=%h dv=%0d expected 000/0", bcd_disp, dv_cnt);
      end
      press_hold(16'h0004, 320);
      digits.push_back(3);
      checks++;
      if (bcd_disp !== 12'h003) begin
         errors++;
         $display("FAIL long hold: bcd_disp=%h expected 003", bcd_disp);
      end
   endtask

   task automatic test_clear();
      do_key(8);
      do_key(2);
      do_key(12);
      checks++;
      if (bcd_disp !== 12'h000) begin
         errors++;
         $display("FAIL star: bcd_disp=%h expected 000", bcd_disp);
      end
      do_key(14);
      checks++;
      if (data_out !== 8'd0) begin
         errors++;
         $display("FAIL empty enter: data_out=%0d expected 0", data_out);
      end
      do_key(5);
      do_key(3);
      checks++;
      if (bcd_disp !== 12'h005) begin
         errors++;
         $display("FAIL key A: bcd_disp=%h expected 005", bcd_disp);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) do_key(int'($urandom_range(15, 0)));
      do_key(14);
   endtask

   task automatic test_reset_mid();
      do_key(5);
      do_key(14);
      do_key(6);
      align_frame();
      keys_down = 16'h4000;
      repeat (32) @(negedge sys_clk);
      checks++;
      if (bcd_disp !== 12'h006 || data_out !== 8'd5 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL pre-reset: bcd=%h dout=%0d dv=%b expected 006/5/0", bcd_disp, data_out, data_valid);
      end
      sys_rst_n = 1'b0;
      keys_down = '0;
      digits.delete();
      #1;
      checks++;
      if ({key_row, bcd_disp, data_out, data_valid, overflow} !== {4'b1110, 22'd0}) begin
         errors++;
         $display("FAIL mid reset: row=%b bcd=%h dout=%0d dv=%b ovf=%b expected 1110/000/0/0/0",
                  key_row, bcd_disp, data_out, data_valid, overflow);
      end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      dv_cnt = 0;
      repeat (96) begin
         if (data_valid) dv_cnt++;
         @(negedge sys_clk);
      end
      checks++;
      if (dv_cnt !== 0 || data_out !== 8'd0) begin
         errors++;
         $display("FAIL post reset: dv=%0d dout=%0d expected 0/0", dv_cnt, data_out);
      end
   endtask

   initial begin
      sys_rst_n = 1'b0;
      keys_down = '0;
      test_reset();
      test_basic_entry();
      test_overflow();
      test_debounce();
      test_clear();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
